// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: state encoding, requester IDs and timing default shared by flash_read_arbiter
package flash_arb_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, LATCH, RECOVER} state_t;
  typedef enum logic {REQ_AUD = 1'b0, REQ_ARM = 1'b1} req_id_t;
  localparam int WAIT_CYCLES_DEF = 3;
endpackage

// File: rtl/flash_read_arbiter_if.sv
// flash_read_arbiter_if: requester handshakes and parallel NOR flash pins of flash_read_arbiter
interface flash_read_arbiter_if #(parameter int ADDR_W = 23);
  logic AUD_REQ, AUD_ACK, ARM_REQ, ARM_ACK;
  logic [ADDR_W-1:0] AUD_ADDR, ARM_ADDR, FLASH_ADDR;
  logic [15:0] AUD_DATA, ARM_DATA, FLASH_DATA_IN;
  logic FLASH_NCE, FLASH_NOE_E, FLASH_NWE, FLASH_NBYTE, FLASH_NRESET, FLASH_NWP, BUSY;
  modport slave (
    input AUD_REQ, AUD_ADDR, ARM_REQ, ARM_ADDR, FLASH_DATA_IN,
    output AUD_ACK, AUD_DATA, ARM_ACK, ARM_DATA, FLASH_ADDR, FLASH_NCE, FLASH_NOE_E,
      FLASH_NWE, FLASH_NBYTE, FLASH_NRESET, FLASH_NWP, BUSY
  );
  modport master (
    output AUD_REQ, AUD_ADDR, ARM_REQ, ARM_ADDR, FLASH_DATA_IN,
    input AUD_ACK, AUD_DATA, ARM_ACK, ARM_DATA, FLASH_ADDR, FLASH_NCE, FLASH_NOE_E,
      FLASH_NWE, FLASH_NBYTE, FLASH_NRESET, FLASH_NWP, BUSY
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: audio/ARM read arbiter for a word-mode NOR flash.
// Define FLASH_ARB_RR_EN for round-robin arbitration; otherwise audio has fixed priority.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W = 23
) (
  input logic SYS_CLK,
  input logic SYS_RST_N,
  flash_read_arbiter_if.slave bus
);
  state_t state;
  logic [3:0] cnt;
  req_id_t gnt, win;
  logic [ADDR_W-1:0] win_addr;
`ifdef FLASH_ARB_RR_EN
  req_id_t last;
  function automatic req_id_t pick(input logic aud, input logic arm, input req_id_t prev);
    return (aud && arm) ? (prev == REQ_ARM ? REQ_AUD : REQ_ARM) : (aud ? REQ_AUD : REQ_ARM);
  endfunction
  assign win = pick(bus.AUD_REQ, bus.ARM_REQ, last);
`else
  function automatic req_id_t pick(input logic aud);
    return aud ? REQ_AUD : REQ_ARM;
  endfunction
  assign win = pick(bus.AUD_REQ);
`endif
  assign win_addr = win == REQ_AUD ? bus.AUD_ADDR : bus.ARM_ADDR;
  // BUSY also covers the IDLE cycle in which a pending request is being granted
  assign bus.BUSY = state != IDLE || (SYS_RST_N && (bus.AUD_REQ || bus.ARM_REQ));
  assign bus.FLASH_NWE = 1'b1;
  assign bus.FLASH_NBYTE = 1'b1;
  assign bus.FLASH_NWP = 1'b0;
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N)
    if (!SYS_RST_N) begin
      state <= IDLE;
      cnt <= '0;
      gnt <= REQ_AUD;
      bus.FLASH_ADDR <= '0;
      bus.FLASH_NCE <= 1'b1;
      bus.FLASH_NOE_E <= 1'b1;
      bus.FLASH_NRESET <= 1'b0;
      bus.AUD_ACK <= 1'b0;
      bus.ARM_ACK <= 1'b0;
      bus.AUD_DATA <= '0;
      bus.ARM_DATA <= '0;
`ifdef FLASH_ARB_RR_EN
      last <= REQ_ARM;
`endif
    end else begin
      bus.FLASH_NRESET <= 1'b1;
      case (state)
        IDLE: if (bus.AUD_REQ || bus.ARM_REQ) begin
          gnt <= win;
          bus.FLASH_ADDR <= win_addr;
          bus.FLASH_NCE <= 1'b0;
          state <= SETUP;
`ifdef FLASH_ARB_RR_EN
          last <= win;
`endif
        end
        SETUP: begin
          bus.FLASH_NOE_E <= 1'b0;
          cnt <= 4'(WAIT_CYCLES - 1);
          state <= STROBE;
        end
        // data is captured as the strobe expires so it is valid alongside ACK
        STROBE: if (cnt == '0) begin
          state <= LATCH;
          if (gnt == REQ_AUD) begin
            bus.AUD_ACK <= 1'b1;
            bus.AUD_DATA <= bus.FLASH_DATA_IN;
          end else begin
            bus.ARM_ACK <= 1'b1;
            bus.ARM_DATA <= bus.FLASH_DATA_IN;
          end
        end else cnt <= cnt - 4'd1;
        LATCH: begin
          bus.AUD_ACK <= 1'b0;
          bus.ARM_ACK <= 1'b0;
          bus.FLASH_NCE <= 1'b1;
          bus.FLASH_NOE_E <= 1'b1;
          state <= RECOVER;
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: directed checks of flash_read_arbiter against a phase-count reference model
`timescale 1ns/1ps
module tb_flash_read_arbiter;
  import flash_arb_pkg::*;
  localparam int W = 3;
`ifdef FLASH_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int n_chk = 0, n_fail = 0;
  int noe_lo = 0, aud_acks = 0, arm_acks = 0;
  always #5 clk = ~clk;
  flash_read_arbiter_if #(.ADDR_W(23)) b ();
  flash_read_arbiter_if #(.ADDR_W(23)) s1 ();
  flash_read_arbiter_if #(.ADDR_W(23)) s15 ();
  flash_read_arbiter #(.WAIT_CYCLES(W), .ADDR_W(23)) dut (.SYS_CLK(clk), .SYS_RST_N(rst_n), .bus(b));
  flash_read_arbiter #(.WAIT_CYCLES(1), .ADDR_W(23)) dut1 (.SYS_CLK(clk), .SYS_RST_N(rst_n), .bus(s1));
  flash_read_arbiter #(.WAIT_CYCLES(15), .ADDR_W(23)) dut15 (.SYS_CLK(clk), .SYS_RST_N(rst_n), .bus(s15));

  function automatic logic [15:0] flash_word(input logic [22:0] a);
    return a == 23'h100 ? 16'hBEEF : a[15:0] ^ 16'h5A5A;
  endfunction
  assign b.FLASH_DATA_IN = flash_word(b.FLASH_ADDR);
  assign s1.FLASH_DATA_IN = flash_word(s1.FLASH_ADDR);
  assign s15.FLASH_DATA_IN = flash_word(s15.FLASH_ADDR);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: p counts cycles since the grant edge (0 = idle, W+2 = ack cycle, W+3 = last)
  int p = 0;
  req_id_t m_gnt = REQ_AUD, m_last = REQ_ARM;
  logic [22:0] m_addr = '0;
  logic [15:0] m_aud = '0, m_arm = '0;
  logic m_nrst = 1'b0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      p = 0; m_addr = '0; m_aud = '0; m_arm = '0; m_nrst = 1'b0; m_last = REQ_ARM;
    end else begin
      m_nrst = 1'b1;
      if (p == 0 && (b.AUD_REQ || b.ARM_REQ)) begin
        m_gnt = !b.ARM_REQ ? REQ_AUD : !b.AUD_REQ ? REQ_ARM :
                (RR && m_last == REQ_AUD) ? REQ_ARM : REQ_AUD;
        m_last = m_gnt;
        m_addr = m_gnt == REQ_AUD ? b.AUD_ADDR : b.ARM_ADDR;
        p = 1;
      end else if (p == W + 3) p = 0;
      else if (p != 0) begin
        p++;
        if (p == W + 2) begin
          if (m_gnt == REQ_AUD) m_aud = flash_word(m_addr);
          else m_arm = flash_word(m_addr);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    noe_lo += int'(!b.FLASH_NOE_E);
    aud_acks += int'(b.AUD_ACK);
    arm_acks += int'(b.ARM_ACK);
    if (chk_en) begin
      chk("FLASH_NCE", b.FLASH_NCE, !(p >= 1 && p <= W + 2));
      chk("FLASH_NOE_E", b.FLASH_NOE_E, !(p >= 2 && p <= W + 2));
      chk("AUD_ACK", b.AUD_ACK, p == W + 2 && m_gnt == REQ_AUD);
      chk("ARM_ACK", b.ARM_ACK, p == W + 2 && m_gnt == REQ_ARM);
      chk("AUD_DATA", b.AUD_DATA, m_aud);
      chk("ARM_DATA", b.ARM_DATA, m_arm);
      chk("FLASH_ADDR", b.FLASH_ADDR, m_addr);
      chk("BUSY", b.BUSY, p != 0 || (rst_n && (b.AUD_REQ || b.ARM_REQ)));
      chk("FLASH_NRESET", b.FLASH_NRESET, m_nrst);
      chk("FLASH_NWE", b.FLASH_NWE, 1'b1);
      chk("FLASH_NBYTE", b.FLASH_NBYTE, 1'b1);
      chk("FLASH_NWP", b.FLASH_NWP, 1'b0);
    end
  end

  function automatic logic hit(input int which);
    return which == 0 ? b.AUD_ACK : which == 1 ? b.ARM_ACK : (b.AUD_ACK | b.ARM_ACK);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // n = number of falling edges after the next rising edge up to and including the ACK sample
  task automatic wait_ack(input int which, input int limit, output int n);
    n = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
    end while (!hit(which) && n < limit);
    chk($sformatf("ack%0d_seen", which), hit(which), 1'b1);
  endtask

  initial begin
    int n, a0, a1, nl, l1, l15, b1, b15;
    int ids[4];
    b.AUD_REQ = 0; b.ARM_REQ = 0; b.AUD_ADDR = '0; b.ARM_ADDR = '0;
    s1.AUD_REQ = 0; s1.ARM_REQ = 0; s1.AUD_ADDR = '0; s1.ARM_ADDR = '0;
    s15.AUD_REQ = 0; s15.ARM_REQ = 0; s15.AUD_ADDR = '0; s15.ARM_ADDR = '0;
    #1 rst_n = 1'b0;
    tick(3);
    chk_en = 1'b1;
    chk("rst_nce", b.FLASH_NCE, 1'b1);
    chk("rst_noe", b.FLASH_NOE_E, 1'b1);
    chk("rst_addr", b.FLASH_ADDR, 0);
    chk("rst_busy", b.BUSY, 1'b0);
    chk("rst_nreset", b.FLASH_NRESET, 1'b0);
    chk("rst_aud_data", b.AUD_DATA, 0);
    rst_n = 1'b1;
    tick(2);
    // single read
    nl = noe_lo; a1 = arm_acks;
    b.AUD_ADDR = 23'h100; b.AUD_REQ = 1;
    wait_ack(0, 20, n);
    chk("single_latency", n, 5);
    tick(1); b.AUD_REQ = 0;
    tick(4);
    chk("single_data", b.AUD_DATA, 16'hBEEF);
    chk("single_noe_cycles", noe_lo - nl, 4);
    chk("single_arm_ack", arm_acks - a1, 0);
    // contention with both requests held from reset
    rst_n = 1'b0;
    b.AUD_ADDR = 23'h200; b.ARM_ADDR = 23'h300; b.AUD_REQ = 1; b.ARM_REQ = 1;
    tick(2); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(2, 30, n);
      ids[k] = int'(b.ARM_ACK);
      chk($sformatf("contend_gap%0d", k), n, k == 0 ? 5 : 7);
      chk($sformatf("contend_order%0d", k), ids[k], RR ? k % 2 : 0);
    end
    tick(1); b.AUD_REQ = 0;
    wait_ack(2, 30, n);
    chk("after_drop_gap", n, 6);
    chk("after_drop_arm", b.ARM_ACK, 1'b1);
    tick(1); b.ARM_REQ = 0;
    chk("contend_arm_data", b.ARM_DATA, 16'h595A);
    chk("contend_aud_data", b.AUD_DATA, 16'h585A);
    // reset asserted during the strobe
    tick(3);
    b.ARM_ADDR = 23'h400; b.ARM_REQ = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b.FLASH_NOE_E && n < 10);
    chk("strobe_reached", b.FLASH_NOE_E, 1'b0);
    tick(1); rst_n = 1'b0; b.ARM_REQ = 0;
    a0 = aud_acks; a1 = arm_acks;
    #1;
    chk("abort_nce", b.FLASH_NCE, 1'b1);
    chk("abort_noe", b.FLASH_NOE_E, 1'b1);
    chk("abort_busy", b.BUSY, 1'b0);
    tick(2); rst_n = 1'b1;
    tick(3);
    chk("abort_no_ack", aud_acks + arm_acks - a0 - a1, 0);
    b.AUD_ADDR = 23'h500; b.AUD_REQ = 1;
    wait_ack(0, 20, n);
    chk("fresh_latency", n, 5);
    tick(1); b.AUD_REQ = 0;
    chk("fresh_data", b.AUD_DATA, 16'h5F5A);
    // one-cycle request pulse at the top address
    tick(2);
    a1 = arm_acks;
    b.ARM_ADDR = 23'h7FFFFF; b.ARM_REQ = 1;
    tick(1); b.ARM_REQ = 0; b.ARM_ADDR = '0;
    tick(10);
    chk("drop_ack_count", arm_acks - a1, 1);
    chk("drop_data", b.ARM_DATA, 16'hA5A5);
    chk("drop_addr_held", b.FLASH_ADDR, 23'h7FFFFF);
    chk("drop_idle", b.BUSY, 1'b0);
    // wait-cycle sweep on the WAIT_CYCLES=1 and 15 instances
    s1.AUD_ADDR = 23'h10; s15.AUD_ADDR = 23'h10; s1.AUD_REQ = 1; s15.AUD_REQ = 1;
    l1 = 0; l15 = 0; b1 = 0; b15 = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      b1 += int'(s1.BUSY);
      b15 += int'(s15.BUSY);
      if (s1.AUD_ACK && l1 == 0) l1 = i;
      if (s15.AUD_ACK && l15 == 0) l15 = i;
      @(posedge clk);
      #2;
      if (l1 != 0) s1.AUD_REQ = 0;
      if (l15 != 0) s15.AUD_REQ = 0;
    end
    chk("sweep1_latency", l1, 3);
    chk("sweep15_latency", l15, 17);
    chk("sweep1_busy", b1, 5);
    chk("sweep15_busy", b15, 19);
    chk("sweep1_data", s1.AUD_DATA, 16'h5A4A);
    chk("sweep15_data", s15.AUD_DATA, 16'h5A4A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/flash_read_arbiter.md
FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3: cycles with FLASH_NOE_E low before data capture; legal range 1..15.
REQ-002 Parameter ADDR_W, default 23: flash word-address width.
REQ-003 Port SYS_CLK, input, 1: single clock, 24 MHz; all logic on its rising edge.
REQ-004 Port SYS_RST_N, input, 1: reset, asynchronous, active-low.
REQ-005 Ports AUD_REQ (input, 1), AUD_ADDR (input, ADDR_W), AUD_ACK (output, 1), AUD_DATA (output, 16): audio sample-fetch requester.
REQ-006 Ports ARM_REQ (input, 1), ARM_ADDR (input, ADDR_W), ARM_ACK (output, 1), ARM_DATA (output, 16): ARM-bus requester.
REQ-007 Ports FLASH_ADDR (output, ADDR_W), FLASH_DATA_IN (input, 16), FLASH_NCE, FLASH_NOE_E, FLASH_NWE, FLASH_NBYTE, FLASH_NRESET, FLASH_NWP (outputs, 1 each).
REQ-008 Port BUSY (output, 1): high whenever the state is not IDLE.

Function
REQ-009 States: IDLE, SETUP, STROBE, LATCH, RECOVER; one transaction per pass.
REQ-010 IDLE: at a rising edge with any REQ high, grant one requester, register its address into FLASH_ADDR, go to SETUP.
REQ-011 SETUP (1 cycle): FLASH_NCE low, FLASH_NOE_E high; then STROBE.
REQ-012 STROBE (WAIT_CYCLES cycles, 4-bit down-counter): FLASH_NCE low, FLASH_NOE_E low; at expiry go to LATCH.
REQ-013 LATCH (1 cycle): FLASH_DATA_IN registered into the granted requester's DATA register; that requester's ACK high for exactly this one cycle; FLASH_NCE, FLASH_NOE_E still low.
REQ-014 RECOVER (1 cycle): FLASH_NCE and FLASH_NOE_E high; then IDLE.
REQ-015 Latency: REQ sampled at edge n gives ACK high in cycle n+2+WAIT_CYCLES; repeat period is WAIT_CYCLES+4 cycles (7 at default).
REQ-016 DATA outputs hold their last captured value until the next ACK for the same requester.
REQ-017 Requesters hold REQ and ADDR stable until ACK; REQ may drop in the ACK cycle.
REQ-018 A requester's REQ still high in IDLE after its ACK starts a new transaction.
REQ-019 REQ dropped mid-transaction: the transaction completes and ACK still pulses; FLASH_ADDR does not change mid-transaction.
REQ-020 Both REQs high in IDLE: arbitration per REQ-026/REQ-027; the loser waits, and ACKs never overlap.
REQ-021 FLASH_NWE and FLASH_NBYTE are constant 1 (read-only, word mode); FLASH_NWP is constant 0.
REQ-022 FLASH_NRESET is 0 during reset and 1 from the first clock edge after SYS_RST_N rises.

Reset
REQ-023 While SYS_RST_N is low, the state is IDLE immediately (asynchronous).
REQ-024 Reset values: FLASH_NCE=1, FLASH_NOE_E=1, FLASH_ADDR=0, both ACKs=0, both DATA=0, BUSY=0, wait counter=0, round-robin pointer=ARM (audio wins first).
REQ-025 A reset asserted mid-transaction aborts it with no ACK; FLASH_NCE and FLASH_NOE_E go high without waiting for a clock.

Configuration
REQ-026 Macro FLASH_ARB_RR_EN defined: round-robin arbitration; on contention, the requester not served last wins; the pointer updates at each grant.
REQ-027 Macro FLASH_ARB_RR_EN undefined: fixed priority, AUD always wins over ARM; the pointer logic is absent.

Structure
REQ-028 Shared package flash_arb_pkg holds the state encoding enum, the requester-ID encoding (AUD=0, ARM=1) and the WAIT_CYCLES default constant.
REQ-029 Single module; no sub-module; the arbiter decision is a combinational function inside it.

Verification
REQ-030 Single read: WAIT_CYCLES=3, AUD_REQ with AUD_ADDR=0x000100, flash model returns 0xBEEF -> AUD_ACK high 5 cycles after the REQ edge; AUD_DATA=0xBEEF; FLASH_NOE_E low exactly 4 cycles; ARM_ACK stays 0.
REQ-031 Contention with FLASH_ARB_RR_EN: both REQs held high from reset for 4 transactions -> ACK order AUD, ARM, AUD, ARM; each ACK 7 cycles apart.
REQ-032 Contention without the macro: both REQs held high -> every ACK is AUD_ACK; ARM_ACK appears only after AUD_REQ drops.
REQ-033 Mid-transaction reset: assert SYS_RST_N low during STROBE -> FLASH_NCE and FLASH_NOE_E high before the next edge; no ACK; after release, a fresh request completes normally.
REQ-034 Early drop: ARM_REQ pulsed for 1 cycle at ARM_ADDR=0x7FFFFF -> full cycle runs; FLASH_ADDR=0x7FFFFF held stable through RECOVER; ARM_ACK pulses once; the block returns to IDLE.
REQ-035 Timing sweep: WAIT_CYCLES=1 and 15 -> ACK latency 3 and 17 cycles respectively; BUSY high for 5 and 19 cycles.
